riscv_rib_arb: RTL

RISCV_RIB_ARB -- requirements
Module: riscv_rib_arb

---
 rtl/riscv_rib_arb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/riscv_rib_arb.sv
// Round-robin arbiter granting MST_NUM masters one-at-a-time access to a shared RIB bus.
// Optional BUSY watchdog enabled by RIB_ARB_TIMEOUT_EN (forced error response after TIMEOUT_CYC cycles).
module riscv_rib_arb #(
   parameter int MST_NUM     = 3,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic [MST_NUM-1:0]    mst_req,
   input  logic [MST_NUM-1:0]    mst_wr_en,
   input  logic [MST_NUM*32-1:0] mst_addr,
   input  logic [MST_NUM*32-1:0] mst_wdata,
   output logic [MST_NUM-1:0]    mst_gnt,
   output logic [MST_NUM-1:0]    mst_rvalid,
   output logic [31:0]           mst_rdata,
   output logic                  mst_err,
   output logic                  bus_req,
   output logic                  bus_wr_en,
   output logic [31:0]           bus_addr,
   output logic [31:0]           bus_wdata,
   input  logic                  bus_ack,
   input  logic [31:0]           bus_rdata,
   output logic                  core_hold
);
   localparam int IW = $clog2(MST_NUM);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
   typedef struct packed {
      logic        wr_en;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, win;
   logic          any_req, tmo, pend0, err_q;
   cmd_t          cmd, win_cmd;
   logic [31:0]   rdata_q;

   // first requester strictly after the previous winner, wrapping around
   always_comb begin
      win     = ptr;
      any_req = 1'b0;
      for (int k = 1; k <= MST_NUM; k++)
         for (int i = 0; i < MST_NUM; i++)
            if (!any_req && mst_req[i] && ((int'(ptr) + k) % MST_NUM) == i) begin
               win     = IW'(i);
               any_req = 1'b1;
            end
   end

   always_comb begin
      win_cmd = '0;
      for (int i = 0; i < MST_NUM; i++)
         if (win == IW'(i))
            win_cmd = '{mst_wr_en[i], mst_addr[32*i +: 32], mst_wdata[32*i +: 32]};
   end

   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (bus_ack || tmo) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         ptr     <= IW'(MST_NUM - 1);
         cmd     <= '0;
         rdata_q <= '0;
         pend0   <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            ptr <= win;
            cmd <= win_cmd;
         end
         if (state == BUSY) begin
            if (bus_ack)  rdata_q <= bus_rdata;
            else if (tmo) rdata_q <= '0;
         end
         if (mst_gnt[0])         pend0 <= 1'b1;
         else if (mst_rvalid[0]) pend0 <= 1'b0;
      end

`ifdef RIB_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // an ack in the last allowed cycle completes normally
   assign tmo = (state == BUSY) && !bus_ack && (tmo_cnt == 8'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state != BUSY) tmo_cnt <= '0;
         else if (!bus_ack) tmo_cnt <= tmo_cnt + 8'd1;
         if (state == BUSY && (bus_ack || tmo)) err_q <= ~bus_ack;
      end
`else
   assign tmo   = 1'b0;
   assign err_q = 1'b0;
`endif

   // outputs are gated by rst_b so an asserted reset silences them in the same cycle
   always_comb begin
      mst_gnt    = '0;
      mst_rvalid = '0;
      mst_rdata  = '0;
      mst_err    = 1'b0;
      bus_req    = 1'b0;
      bus_wr_en  = 1'b0;
      bus_addr   = '0;
      bus_wdata  = '0;
      if (rst_b) begin
         case (state)
            IDLE: if (any_req)
                     for (int i = 0; i < MST_NUM; i++) mst_gnt[i] = (win == IW'(i));
            BUSY: begin
               bus_req   = 1'b1;
               bus_wr_en = cmd.wr_en;
               bus_addr  = cmd.addr;
               bus_wdata = cmd.wdata;
            end
            RESP: begin
               for (int i = 0; i < MST_NUM; i++) mst_rvalid[i] = (ptr == IW'(i));
               mst_rdata = rdata_q;
               mst_err   = err_q;
            end
            default: ;
         endcase
      end
      core_hold = rst_b & ((mst_req[0] & ~mst_gnt[0]) | (pend0 & ~mst_rvalid[0]));
   end

endmodule
